// File: rtl/accum_dump_param.sv
// accum_dump_param: integrate-and-dump accumulator with wrap/saturate and per-block overflow flag
module accum_dump_param #(
  parameter int IN_W = 3,
  parameter int ACC_W = 7,
  parameter int N_ACC = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [IN_W-1:0]                            in1,
  input  logic [IN_W-1:0]                            in2,
  input  logic [1:0]                                 sel,
  input  logic                                       in_valid,
  input  logic                                       sat,
  input  logic                                       clr,
  output logic [ACC_W-1:0]                           out_data,
  output logic                                       out_valid,
  output logic                                       out_ovf,
  output logic [ACC_W-1:0]                           acc_out,
  output logic [(N_ACC > 1 ? $clog2(N_ACC) : 1)-1:0] cnt_out
);
  localparam int CNT_W = N_ACC > 1 ? $clog2(N_ACC) : 1;
  logic sticky, sub, e, last;
  logic [IN_W:0] op;
  logic [ACC_W:0] ext, nx;
  logic [ACC_W-1:0] r;
  always_comb begin
    sub = sel == 2'b11;
    op = sel == 2'b01 ? {1'b0, in2} : sel == 2'b10 ? {1'b0, in1} + {1'b0, in2} : {1'b0, in1};
    ext = {{(ACC_W-IN_W){1'b0}}, op};
    nx = sub ? {1'b0, acc_out} - ext : {1'b0, acc_out} + ext;
    e = nx[ACC_W];
    r = (e & sat) ? (sub ? '0 : '1) : nx[ACC_W-1:0];
    last = cnt_out == CNT_W'(N_ACC-1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_out <= '0;
      cnt_out <= '0;
      sticky <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        acc_out <= '0;
        cnt_out <= '0;
        sticky <= 1'b0;
      end else if (in_valid) begin
        acc_out <= last ? '0 : r;
        cnt_out <= last ? '0 : cnt_out + 1'b1;
        sticky <= last ? 1'b0 : sticky | e;
        if (last) begin
          out_data <= r;
          out_ovf <= sticky | e;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_accum_dump_param.sv
// tb_accum_dump_param: table vectors, corner sequences and random stimulus against an arithmetic model
module tb_accum_dump_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, sat, clr;
  logic [2:0] in1, in2;
  logic [1:0] sel;
  logic [6:0] od [3];
  logic [6:0] ac [3];
  logic ov [3];
  logic of [3];
  logic [1:0] c4;
  logic [3:0] c16;
  logic c1;
  accum_dump_param #(.N_ACC(4)) dut (.clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sel(sel),
    .in_valid(in_valid), .sat(sat), .clr(clr), .out_data(od[0]), .out_valid(ov[0]),
    .out_ovf(of[0]), .acc_out(ac[0]), .cnt_out(c4));
  accum_dump_param #(.N_ACC(16)) dut16 (.clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sel(sel),
    .in_valid(in_valid), .sat(sat), .clr(clr), .out_data(od[1]), .out_valid(ov[1]),
    .out_ovf(of[1]), .acc_out(ac[1]), .cnt_out(c16));
  accum_dump_param #(.N_ACC(1)) dut1 (.clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sel(sel),
    .in_valid(in_valid), .sat(sat), .clr(clr), .out_data(od[2]), .out_valid(ov[2]),
    .out_ovf(of[2]), .acc_out(ac[2]), .cnt_out(c1));
  int pass = 0, total = 0;
  int nacc [3] = '{4, 16, 1};
  int m_acc [3], m_cnt [3], m_st [3], m_od [3], m_ov [3], m_of [3];
  typedef struct {
    bit rn, iv, s, cl;
    int a, b, sl;
    int ea, ec, eo, ev, ef;
  } vec_t;
  vec_t t [$];
  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a == e) pass++;
    else $display("FAIL %s got %0h expected %0h", nm, a, e);
  endtask
  function automatic int cnt_of(input int i);
    return i == 0 ? int'(c4) : i == 1 ? int'(c16) : int'(c1);
  endfunction
  function automatic int pk(input int a, input int c, input int o, input int v, input int f);
    return (a << 16) | (c << 11) | (o << 2) | (v << 1) | f;
  endfunction
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_st[i] = 0; m_od[i] = 0; m_ov[i] = 0; m_of[i] = 0;
      end else begin
        m_ov[i] = 0;
        if (clr) begin
          m_acc[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
        end else if (in_valid) begin
          int op, nx, r, e;
          op = sel == 0 ? int'(in1) : sel == 1 ? int'(in2) : sel == 2 ? int'(in1) + int'(in2) : int'(in1);
          nx = sel == 3 ? m_acc[i] - op : m_acc[i] + op;
          e = (nx > 127 || nx < 0) ? 1 : 0;
          r = !e ? nx : sat ? (nx < 0 ? 0 : 127) : ((nx % 128) + 128) % 128;
          if (m_cnt[i] == nacc[i] - 1) begin
            m_od[i] = r; m_of[i] = m_st[i] | e; m_ov[i] = 1;
            m_acc[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
          end else begin
            m_acc[i] = r; m_cnt[i]++; m_st[i] |= e;
          end
        end
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("model_n%0d", nacc[i]),
          pk(int'(ac[i]), cnt_of(i), int'(od[i]), int'(ov[i]), int'(of[i])),
          pk(m_acc[i], m_cnt[i], m_od[i], m_ov[i], m_of[i]));
  endtask
  task automatic drive(input bit rn, input bit iv, input bit s, input bit cl, input int a, input int b, input int sl);
    rst_n = rn; in_valid = iv; sat = s; clr = cl;
    in1 = 3'(a); in2 = 3'(b); sel = 2'(sl);
  endtask
  function automatic void add(input bit rn, input bit iv, input bit s, input bit cl, input int a, input int b,
                              input int sl, input int ea, input int ec, input int eo, input int ev, input int ef);
    vec_t v;
    v.rn = rn; v.iv = iv; v.s = s; v.cl = cl; v.a = a; v.b = b; v.sl = sl;
    v.ea = ea; v.ec = ec; v.eo = eo; v.ev = ev; v.ef = ef;
    t.push_back(v);
  endfunction
  initial begin
    drive(0, 1, 0, 0, 7, 7, 2);
    add(0, 1, 0, 0, 7, 7, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 7, 7, 2, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 7, 7, 2, 14, 1, 0, 0, 0);
    add(1, 1, 0, 0, 7, 7, 2, 28, 2, 0, 0, 0);
    add(1, 1, 0, 0, 7, 7, 2, 42, 3, 0, 0, 0);
    add(1, 1, 0, 0, 7, 7, 2, 0, 0, 56, 1, 0);
    add(1, 0, 0, 0, 7, 7, 2, 0, 0, 56, 0, 0);
    add(1, 1, 0, 0, 3, 0, 0, 3, 1, 56, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 3, 1, 56, 0, 0);
    add(1, 1, 0, 0, 3, 0, 0, 6, 2, 56, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 6, 2, 56, 0, 0);
    add(1, 1, 0, 0, 3, 0, 0, 9, 3, 56, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 9, 3, 56, 0, 0);
    add(1, 1, 0, 0, 3, 0, 0, 0, 0, 12, 1, 0);
    add(1, 0, 0, 0, 3, 0, 0, 0, 0, 12, 0, 0);
    add(1, 1, 0, 0, 5, 0, 3, 123, 1, 12, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 125, 2, 12, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 127, 3, 12, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1, 1);
    add(1, 1, 1, 0, 5, 0, 3, 0, 1, 1, 0, 1);
    add(1, 1, 1, 0, 2, 0, 0, 2, 2, 1, 0, 1);
    add(1, 1, 1, 0, 2, 0, 0, 4, 3, 1, 0, 1);
    add(1, 1, 1, 0, 2, 0, 0, 0, 0, 6, 1, 1);
    add(1, 1, 0, 0, 3, 0, 0, 3, 1, 6, 0, 1);
    add(1, 1, 0, 0, 3, 0, 0, 6, 2, 6, 0, 1);
    add(1, 1, 0, 1, 3, 0, 0, 0, 0, 6, 0, 1);
    add(1, 1, 0, 0, 1, 0, 0, 1, 1, 6, 0, 1);
    add(1, 1, 0, 0, 1, 0, 0, 2, 2, 6, 0, 1);
    add(1, 1, 0, 0, 1, 0, 0, 3, 3, 6, 0, 1);
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0);
    add(1, 1, 0, 0, 2, 0, 0, 2, 1, 4, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 4, 2, 4, 0, 0);
    add(0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 2, 1, 0, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 4, 2, 0, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 6, 3, 0, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 0, 0, 8, 1, 0);
    foreach (t[k]) begin
      drive(t[k].rn, t[k].iv, t[k].s, t[k].cl, t[k].a, t[k].b, t[k].sl);
      step();
      chk($sformatf("vec%0d", k), pk(int'(ac[0]), int'(c4), int'(od[0]), int'(ov[0]), int'(of[0])),
          pk(t[k].ea, t[k].ec, t[k].eo, t[k].ev, t[k].ef));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 1, 0, 7, 7, 2);
      step();
      if (k < 15) chk("n16_no_pulse", int'(ov[1]), 0);
    end
    chk("n16_data", int'(od[1]), 127);
    chk("n16_ovf", int'(of[1]), 1);
    chk("n16_valid", int'(ov[1]), 1);
    drive(1, 1, 0, 0, 5, 0, 0);
    step();
    chk("n1_dump_a", pk(int'(ac[2]), int'(c1), int'(od[2]), int'(ov[2]), int'(of[2])), pk(0, 0, 5, 1, 0));
    drive(1, 1, 0, 0, 6, 0, 0);
    step();
    chk("n1_dump_b", pk(int'(ac[2]), int'(c1), int'(od[2]), int'(ov[2]), int'(of[2])), pk(0, 0, 6, 1, 0));
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      step();
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
